// File: rtl/rcv_fifo_ctrl_pkg.sv
// Shared types and constants for the 3-row receive FIFO controller.
package rcv_fifo_pkg;

    localparam int NUM_ROWS = 3;
    localparam int PTR_BITS = 2;

    typedef logic [PTR_BITS-1:0] ptr_t;

    localparam ptr_t LAST_ROW = ptr_t'(NUM_ROWS - 1);

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_VALID = 1'b1
    } out_state_t;

endpackage

// File: rtl/rcv_fifo_ctrl_if.sv
// Receive FIFO controller signal bundle: receiver writes, storage strobes, consumer handshake.
interface rcv_fifo_ctrl_if;
    import rcv_fifo_pkg::*;

    logic flush;
    logic wr_req;
    logic wr_en;
    ptr_t tail_ptr;
    logic rd_en;
    ptr_t head_ptr;
    logic rd_valid;
    logic rd_ready;
    logic full;
    logic empty;
    ptr_t count;
    logic overrun;

    // Environment side: receiver, storage array and consumer.
    modport master (
        output flush, wr_req, rd_ready,
        input  wr_en, tail_ptr, rd_en, head_ptr, rd_valid, full, empty, count, overrun
    );

    // Controller side.
    modport slave (
        input  flush, wr_req, rd_ready,
        output wr_en, tail_ptr, rd_en, head_ptr, rd_valid, full, empty, count, overrun
    );
endinterface

// File: rtl/rcv_fifo_ctrl_ptr_ctr.sv
// Mod-3 row pointer with wrap toggle; advances on inc, clr wins over inc.
// One-cycle update, no backpressure of its own.
module rcv_ptr_ctr
    import rcv_fifo_pkg::*;
(
    input  logic clk,
    input  logic n_rst,
    input  logic inc,
    input  logic clr,
    output ptr_t ptr,
    output logic tog
);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ptr <= '0;
            tog <= 1'b0;
        end else if (clr) begin
            ptr <= '0;
            tog <= 1'b0;
        end else if (inc) begin
            if (ptr == LAST_ROW) begin
                ptr <= '0;
                tog <= ~tog;
            end else begin
                ptr <= ptr + ptr_t'(1);
            end
        end
    end

endmodule

// File: rtl/rcv_fifo_ctrl.sv
// Receive FIFO pointer/flag controller with a one-deep registered output stage.
// rd_valid follows rd_en by one cycle; rd_ready low holds the output row and stalls reads.
module rcv_fifo_ctrl
    import rcv_fifo_pkg::*;
(
    input  logic clk,
    input  logic n_rst,
    rcv_fifo_ctrl_if.slave ifc
);

    ptr_t       tail_ptr;
    ptr_t       head_ptr;
    logic       tail_tog;
    logic       head_tog;
    logic       full;
    logic       empty;
    ptr_t       count;
    logic       wr_en;
    logic       rd_en;
    logic       overrun;
    out_state_t state;
    logic [PTR_BITS:0] wrap_count;

    rcv_ptr_ctr u_tail (
        .clk   (clk),
        .n_rst (n_rst),
        .inc   (wr_en),
        .clr   (ifc.flush),
        .ptr   (tail_ptr),
        .tog   (tail_tog)
    );

    rcv_ptr_ctr u_head (
        .clk   (clk),
        .n_rst (n_rst),
        .inc   (rd_en),
        .clr   (ifc.flush),
        .ptr   (head_ptr),
        .tog   (head_tog)
    );

    assign empty = (tail_ptr == head_ptr) && (tail_tog == head_tog);
    assign full  = (tail_ptr == head_ptr) && (tail_tog != head_tog);

    // Differing toggles mean the tail has wrapped once more than the head.
    assign wrap_count = {1'b0, tail_ptr} + (PTR_BITS+1)'(NUM_ROWS) - {1'b0, head_ptr};
    assign count      = (tail_tog == head_tog) ? (tail_ptr - head_ptr) : wrap_count[PTR_BITS-1:0];

    assign wr_en = ifc.wr_req & ~full & ~ifc.flush;
    assign rd_en = ~empty & ~ifc.flush & ((state == OUT_EMPTY) | ifc.rd_ready);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= OUT_EMPTY;
            overrun <= 1'b0;
        end else if (ifc.flush) begin
            state   <= OUT_EMPTY;
            overrun <= 1'b0;
        end else begin
            overrun <= ifc.wr_req & full;
            case (state)
                OUT_EMPTY: if (rd_en) state <= OUT_VALID;
                OUT_VALID: if (ifc.rd_ready && !rd_en) state <= OUT_EMPTY;
                default:   state <= OUT_EMPTY;
            endcase
        end
    end

    assign ifc.wr_en    = wr_en;
    assign ifc.rd_en    = rd_en;
    assign ifc.tail_ptr = tail_ptr;
    assign ifc.head_ptr = head_ptr;
    assign ifc.full     = full;
    assign ifc.empty    = empty;
    assign ifc.count    = count;
    assign ifc.overrun  = overrun;
    assign ifc.rd_valid = (state == OUT_VALID);

endmodule

// File: tb/tb_rcv_fifo_ctrl.sv
// Directed bench for rcv_fifo_ctrl: fill, overrun, drain, stall, flush, streaming and async reset.
module tb_rcv_fifo_ctrl;
    import rcv_fifo_pkg::*;

    logic clk;
    logic n_rst;
    int   total;
    int   bad;

    rcv_fifo_ctrl_if ifc ();

    rcv_fifo_ctrl dut (
        .clk   (clk),
        .n_rst (n_rst),
        .ifc   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        ifc.flush = 1'b0;
        ifc.wr_req = 1'b0;
        ifc.rd_ready = 1'b0;
        repeat (2) tick();
        n_rst = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        total++; if (ifc.tail_ptr !== 2'd0) begin bad++; $display("FAIL reset_tail got=%0d want=0", ifc.tail_ptr); end
        total++; if (ifc.head_ptr !== 2'd0) begin bad++; $display("FAIL reset_head got=%0d want=0", ifc.head_ptr); end
        total++; if (ifc.count !== 2'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", ifc.count); end
        total++; if (ifc.empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b want=1", ifc.empty); end
        total++; if (ifc.full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b want=0", ifc.full); end
        total++; if (ifc.rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%b want=0", ifc.rd_valid); end
        total++; if (ifc.overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b want=0", ifc.overrun); end
        total++; if (ifc.wr_en !== 1'b0 || ifc.rd_en !== 1'b0) begin bad++; $display("FAIL reset_strobes got wr=%b rd=%b want 0 0", ifc.wr_en, ifc.rd_en); end
        tick();
    endtask

    // Four writes with the consumer stalled: the first row moves to the output stage, then three fill storage.
    task automatic test_fill_overrun();
        logic exp_rd_en [4]  = '{1'b0, 1'b1, 1'b0, 1'b0};
        ptr_t exp_tail  [4]  = '{2'd1, 2'd2, 2'd0, 2'd1};
        ptr_t exp_count [4]  = '{2'd1, 2'd1, 2'd2, 2'd3};
        logic exp_valid [4]  = '{1'b0, 1'b1, 1'b1, 1'b1};
        ifc.rd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ifc.wr_req = 1'b1;
            @(negedge clk);
            total++; if (ifc.wr_en !== 1'b1) begin bad++; $display("FAIL fill_wr_en[%0d] got=%b want=1", i, ifc.wr_en); end
            total++; if (ifc.rd_en !== exp_rd_en[i]) begin bad++; $display("FAIL fill_rd_en[%0d] got=%b want=%b", i, ifc.rd_en, exp_rd_en[i]); end
            tick();
            total++; if (ifc.tail_ptr !== exp_tail[i]) begin bad++; $display("FAIL fill_tail[%0d] got=%0d want=%0d", i, ifc.tail_ptr, exp_tail[i]); end
            total++; if (ifc.count !== exp_count[i]) begin bad++; $display("FAIL fill_count[%0d] got=%0d want=%0d", i, ifc.count, exp_count[i]); end
            total++; if (ifc.rd_valid !== exp_valid[i]) begin bad++; $display("FAIL fill_rd_valid[%0d] got=%b want=%b", i, ifc.rd_valid, exp_valid[i]); end
        end
        total++; if (ifc.full !== 1'b1) begin bad++; $display("FAIL fill_full got=%b want=1", ifc.full); end
        total++; if (ifc.overrun !== 1'b0) begin bad++; $display("FAIL fill_overrun_pre got=%b want=0", ifc.overrun); end
        // Extra write into a full FIFO.
        ifc.wr_req = 1'b1;
        @(negedge clk);
        total++; if (ifc.wr_en !== 1'b0) begin bad++; $display("FAIL overrun_wr_en got=%b want=0", ifc.wr_en); end
        tick();
        ifc.wr_req = 1'b0;
        total++; if (ifc.overrun !== 1'b1) begin bad++; $display("FAIL overrun_pulse got=%b want=1", ifc.overrun); end
        total++; if (ifc.tail_ptr !== 2'd1) begin bad++; $display("FAIL overrun_tail got=%0d want=1", ifc.tail_ptr); end
        tick();
        total++; if (ifc.overrun !== 1'b0) begin bad++; $display("FAIL overrun_clear got=%b want=0", ifc.overrun); end
    endtask

    // Full, head at 1, output valid: drain with rd_ready held high.
    task automatic test_drain();
        ptr_t exp_head  [3] = '{2'd2, 2'd0, 2'd1};
        ptr_t exp_count [3] = '{2'd2, 2'd1, 2'd0};
        ifc.rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (ifc.rd_en !== 1'b1) begin bad++; $display("FAIL drain_rd_en[%0d] got=%b want=1", i, ifc.rd_en); end
            tick();
            total++; if (ifc.head_ptr !== exp_head[i]) begin bad++; $display("FAIL drain_head[%0d] got=%0d want=%0d", i, ifc.head_ptr, exp_head[i]); end
            total++; if (ifc.count !== exp_count[i]) begin bad++; $display("FAIL drain_count[%0d] got=%0d want=%0d", i, ifc.count, exp_count[i]); end
            total++; if (ifc.rd_valid !== 1'b1) begin bad++; $display("FAIL drain_rd_valid[%0d] got=%b want=1", i, ifc.rd_valid); end
        end
        total++; if (ifc.empty !== 1'b1) begin bad++; $display("FAIL drain_empty got=%b want=1", ifc.empty); end
        @(negedge clk);
        total++; if (ifc.rd_en !== 1'b0) begin bad++; $display("FAIL drain_last_rd_en got=%b want=0", ifc.rd_en); end
        tick();
        total++; if (ifc.rd_valid !== 1'b0) begin bad++; $display("FAIL drain_rd_valid_drop got=%b want=0", ifc.rd_valid); end
    endtask

    // Empty with tail=head=1: build count=1 with output valid, then write and read together.
    task automatic test_simul();
        ifc.rd_ready = 1'b0;
        ifc.wr_req = 1'b1;
        repeat (2) tick();
        total++; if (ifc.count !== 2'd1 || ifc.rd_valid !== 1'b1) begin bad++; $display("FAIL simul_setup got count=%0d valid=%b want 1 1", ifc.count, ifc.rd_valid); end
        ifc.rd_ready = 1'b1;
        @(negedge clk);
        total++; if (ifc.wr_en !== 1'b1 || ifc.rd_en !== 1'b1) begin bad++; $display("FAIL simul_strobes got wr=%b rd=%b want 1 1", ifc.wr_en, ifc.rd_en); end
        tick();
        total++; if (ifc.count !== 2'd1) begin bad++; $display("FAIL simul_count got=%0d want=1", ifc.count); end
        total++; if (ifc.rd_valid !== 1'b1) begin bad++; $display("FAIL simul_rd_valid got=%b want=1", ifc.rd_valid); end
        total++; if (ifc.tail_ptr !== 2'd1 || ifc.head_ptr !== 2'd0) begin bad++; $display("FAIL simul_ptrs got tail=%0d head=%0d want 1 0", ifc.tail_ptr, ifc.head_ptr); end
    endtask

    task automatic test_stall();
        ifc.wr_req = 1'b0;
        ifc.rd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++; if (ifc.rd_en !== 1'b0) begin bad++; $display("FAIL stall_rd_en[%0d] got=%b want=0", i, ifc.rd_en); end
            tick();
            total++; if (ifc.head_ptr !== 2'd0 || ifc.rd_valid !== 1'b1) begin bad++; $display("FAIL stall_hold[%0d] got head=%0d valid=%b want 0 1", i, ifc.head_ptr, ifc.rd_valid); end
        end
    endtask

    task automatic test_flush();
        ifc.wr_req = 1'b1;
        tick();
        total++; if (ifc.count !== 2'd2 || ifc.rd_valid !== 1'b1) begin bad++; $display("FAIL flush_setup got count=%0d valid=%b want 2 1", ifc.count, ifc.rd_valid); end
        ifc.flush = 1'b1;
        ifc.rd_ready = 1'b1;
        @(negedge clk);
        total++; if (ifc.wr_en !== 1'b0 || ifc.rd_en !== 1'b0) begin bad++; $display("FAIL flush_strobes got wr=%b rd=%b want 0 0", ifc.wr_en, ifc.rd_en); end
        tick();
        ifc.flush = 1'b0;
        ifc.wr_req = 1'b0;
        total++; if (ifc.tail_ptr !== 2'd0 || ifc.head_ptr !== 2'd0) begin bad++; $display("FAIL flush_ptrs got tail=%0d head=%0d want 0 0", ifc.tail_ptr, ifc.head_ptr); end
        total++; if (ifc.empty !== 1'b1 || ifc.count !== 2'd0) begin bad++; $display("FAIL flush_empty got empty=%b count=%0d want 1 0", ifc.empty, ifc.count); end
        total++; if (ifc.rd_valid !== 1'b0) begin bad++; $display("FAIL flush_rd_valid got=%b want=0", ifc.rd_valid); end
    endtask

    // Streaming from empty with rd_ready high: one row per cycle after the first-word latency.
    task automatic test_back_to_back();
        logic wr_req_v [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic exp_rd_en[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        ptr_t exp_head [6] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd1};
        logic exp_valid[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        ifc.rd_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            ifc.wr_req = wr_req_v[i];
            @(negedge clk);
            total++; if (ifc.rd_en !== exp_rd_en[i]) begin bad++; $display("FAIL b2b_rd_en[%0d] got=%b want=%b", i, ifc.rd_en, exp_rd_en[i]); end
            tick();
            total++; if (ifc.head_ptr !== exp_head[i]) begin bad++; $display("FAIL b2b_head[%0d] got=%0d want=%0d", i, ifc.head_ptr, exp_head[i]); end
            total++; if (ifc.rd_valid !== exp_valid[i]) begin bad++; $display("FAIL b2b_rd_valid[%0d] got=%b want=%b", i, ifc.rd_valid, exp_valid[i]); end
        end
        ifc.wr_req = 1'b0;
    endtask

    task automatic test_async_reset();
        ifc.rd_ready = 1'b0;
        ifc.wr_req = 1'b1;
        repeat (2) tick();
        total++; if (ifc.rd_valid !== 1'b1 || ifc.count !== 2'd1) begin bad++; $display("FAIL arst_setup got valid=%b count=%0d want 1 1", ifc.rd_valid, ifc.count); end
        #2;
        n_rst = 1'b0;
        #1;
        total++; if (ifc.tail_ptr !== 2'd0 || ifc.head_ptr !== 2'd0) begin bad++; $display("FAIL arst_ptrs got tail=%0d head=%0d want 0 0", ifc.tail_ptr, ifc.head_ptr); end
        total++; if (ifc.rd_valid !== 1'b0 || ifc.empty !== 1'b1 || ifc.count !== 2'd0) begin bad++; $display("FAIL arst_flags got valid=%b empty=%b count=%0d want 0 1 0", ifc.rd_valid, ifc.empty, ifc.count); end
        ifc.wr_req = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        tick();
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_fill_overrun();
        test_drain();
        test_simul();
        test_stall();
        test_flush();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
